// File: rtl/dioptase_pkg.sv
// Shared definitions for the Dioptase memory block: MMIO register addresses,
// framebuffer geometry, interrupt bit indices and the address-region decoder.
package dioptase_pkg;

    localparam logic [17:0] MMIO_PS2          = 18'h3FFF0;
    localparam logic [17:0] MMIO_UART_TX      = 18'h3FFF1;
    localparam logic [17:0] MMIO_UART_RX      = 18'h3FFF2;
    localparam logic [17:0] MMIO_SPI_CTL      = 18'h3FFF3;
    localparam logic [17:0] MMIO_TIMER_RELOAD = 18'h3FFF4;
    localparam logic [17:0] MMIO_TIMER_COUNT  = 18'h3FFF5;

    localparam int unsigned FB_W    = 160;
    localparam int unsigned FB_H    = 120;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned FB_AW   = 15;
    localparam int unsigned PIX_W   = 640;
    localparam int unsigned PIX_H   = 480;

    localparam int unsigned IRQ_TIMER = 0;

    localparam int unsigned SPI_CS_BIT   = 0;
    localparam int unsigned SPI_CLK_BIT  = 1;
    localparam int unsigned SPI_MOSI_BIT = 2;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_FB,
        RGN_MMIO
    } region_e;

    function automatic region_e decode(input logic [17:0] a,
                                       input int unsigned ram_words,
                                       input logic [17:0] fb_base);
        if (a < 18'(ram_words))
            return RGN_RAM;
        else if (a >= fb_base && a < fb_base + 18'(FB_SIZE))
            return RGN_FB;
        else if (a >= MMIO_PS2 && a <= MMIO_TIMER_COUNT)
            return RGN_MMIO;
        else
            return RGN_NONE;
    endfunction

endpackage

// File: rtl/dioptase_mem_fb.sv
// Dual-port 12-bit framebuffer (160x120).
//  cpu_we/cpu_waddr/cpu_wdata : CPU write port (caller gates with clk_en)
//  cpu_ren/cpu_raddr/cpu_rdata: CPU read port, 1-cycle latency, holds when idle
//  vga_addr/vga_valid/pixel   : VGA read port, free-running, 0 when off-screen
module dioptase_mem_fb
    import dioptase_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_we,
    input  logic [FB_AW-1:0] cpu_waddr,
    input  logic [11:0]      cpu_wdata,
    input  logic             cpu_ren,
    input  logic [FB_AW-1:0] cpu_raddr,
    output logic [11:0]      cpu_rdata,
    input  logic [FB_AW-1:0] vga_addr,
    input  logic             vga_valid,
    output logic [11:0]      pixel
);

    logic [11:0] mem [FB_SIZE];

    always_ff @(posedge clk) begin
        if (cpu_we)
            mem[cpu_waddr] <= cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
            pixel     <= '0;
        end else begin
            if (cpu_ren)
                cpu_rdata <= mem[cpu_raddr];
            pixel <= vga_valid ? mem[vga_addr] : '0;
        end
    end

endmodule

// File: rtl/dioptase_mem.sv
// Unified RAM + framebuffer + MMIO block for the Dioptase pipelined CPU.
//  raddr0/rdata0 : instruction fetch (RAM only), 1-cycle latency
//  ren/raddr1/rdata1 : data read, 1-cycle latency, may pop PS2/UART RX
//  wen/waddr/wdata   : byte-enabled write to RAM, framebuffer or MMIO
//  ps2_*, uart_*, sd_spi_*, pixel_*/pixel : peripheral side
//  interrupts        : bit 0 timer pulse, remaining bits 0
//  clk_en low freezes everything except the VGA pixel path.
module dioptase_mem
  import dioptase_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 16384,
  parameter string       INIT_FILE = "mem.hex",
  parameter logic [17:0] FB_BASE   = 18'h30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [17:0] raddr0,
  output logic [31:0] rdata0,
  input  logic        ren,
  input  logic [17:0] raddr1,
  output logic [31:0] rdata1,
  input  logic [3:0]  wen,
  input  logic [17:0] waddr,
  input  logic [31:0] wdata,
  output logic        ps2_ren,
  input  logic [15:0] ps2_data_in,
  input  logic [9:0]  pixel_x_in,
  input  logic [9:0]  pixel_y_in,
  output logic [11:0] pixel,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_wen,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ren,
  output logic        sd_spi_cs,
  output logic        sd_spi_clk,
  output logic        sd_spi_mosi,
  input  logic        sd_spi_miso,
  output logic [15:0] interrupts
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [31:0] ram [RAM_WORDS];

  region_e     rgn0, rgn1, rgnw, rgn1_q;
  logic [31:0] rdata1_q, rd1_next;
  logic [31:0] reload, count;
  logic        timer_irq;
  logic        wr_any;
  logic [11:0] fb_rdata;
  logic [FB_AW-1:0] vga_addr;
  logic        vga_valid;

  always_comb begin
    rgn0   = decode(raddr0, RAM_WORDS, FB_BASE);
    rgn1   = decode(raddr1, RAM_WORDS, FB_BASE);
    rgnw   = decode(waddr, RAM_WORDS, FB_BASE);
    wr_any = |wen;
  end

  // RAM writes live in their own block so reads elsewhere see the pre-edge
  // contents: same-word read+write returns the old data.
  always_ff @(posedge clk) begin
    if (clk_en && rgnw == RGN_RAM) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wen[i])
          ram[waddr[RAM_AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd1_next = '0;
    if (rgn1 == RGN_RAM) begin
      rd1_next = ram[raddr1[RAM_AW-1:0]];
    end else if (rgn1 == RGN_MMIO) begin
      case (raddr1)
        MMIO_PS2:          rd1_next = {16'h0, ps2_data_in};
        MMIO_UART_RX:      rd1_next = {24'h0, uart_rx_data};
        MMIO_SPI_CTL:      rd1_next = {28'h0, sd_spi_miso, sd_spi_mosi,
                                       sd_spi_clk, sd_spi_cs};
        MMIO_TIMER_RELOAD: rd1_next = reload;
        MMIO_TIMER_COUNT:  rd1_next = count;
        default:           rd1_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0       <= '0;
      rdata1_q     <= '0;
      rgn1_q       <= RGN_NONE;
      ps2_ren      <= 1'b0;
      uart_rx_ren  <= 1'b0;
      uart_tx_wen  <= 1'b0;
      uart_tx_data <= '0;
      sd_spi_cs    <= 1'b1;
      sd_spi_clk   <= 1'b0;
      sd_spi_mosi  <= 1'b1;
      reload       <= '0;
      count        <= '0;
      timer_irq    <= 1'b0;
    end else begin
      // Pulses are cleared every cycle, so a frozen pipeline never
      // stretches one.
      ps2_ren     <= 1'b0;
      uart_rx_ren <= 1'b0;
      uart_tx_wen <= 1'b0;
      timer_irq   <= 1'b0;
      if (clk_en) begin
        rdata0 <= (rgn0 == RGN_RAM) ? ram[raddr0[RAM_AW-1:0]] : '0;
        if (ren) begin
          rgn1_q   <= rgn1;
          rdata1_q <= rd1_next;
          if (raddr1 == MMIO_PS2)     ps2_ren     <= 1'b1;
          if (raddr1 == MMIO_UART_RX) uart_rx_ren <= 1'b1;
        end
        if (wr_any && waddr == MMIO_UART_TX) begin
          uart_tx_data <= wdata[7:0];
          uart_tx_wen  <= 1'b1;
        end
        if (wr_any && waddr == MMIO_SPI_CTL) begin
          sd_spi_cs   <= wdata[SPI_CS_BIT];
          sd_spi_clk  <= wdata[SPI_CLK_BIT];
          sd_spi_mosi <= wdata[SPI_MOSI_BIT];
        end
        if (wr_any && waddr == MMIO_TIMER_RELOAD) begin
          reload <= wdata;
          count  <= wdata;
        end else if (reload == '0) begin
          count <= '0;
        end else if (count == 32'd1) begin
          timer_irq <= 1'b1;
          count     <= reload;
        end else begin
          count <= count - 32'd1;
        end
      end
    end
  end

  // Framebuffer reads complete inside the sub-module; the registered region
  // selects them onto rdata1 and holds while ren/clk_en are low.
  assign rdata1 = (rgn1_q == RGN_FB) ? {20'h0, fb_rdata} : rdata1_q;

  always_comb begin
    vga_valid = (pixel_x_in < 10'(PIX_W)) && (pixel_y_in < 10'(PIX_H));
    vga_addr  = 15'(pixel_y_in >> 2) * 15'(FB_W) + 15'(pixel_x_in >> 2);
  end

  always_comb begin
    interrupts            = '0;
    interrupts[IRQ_TIMER] = timer_irq;
  end

  dioptase_mem_fb u_fb (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_we    (clk_en && wr_any && rgnw == RGN_FB),
    .cpu_waddr (15'(waddr - FB_BASE)),
    .cpu_wdata (wdata[11:0]),
    .cpu_ren   (clk_en && ren && rgn1 == RGN_FB),
    .cpu_raddr (15'(raddr1 - FB_BASE)),
    .cpu_rdata (fb_rdata),
    .vga_addr  (vga_addr),
    .vga_valid (vga_valid),
    .pixel     (pixel)
  );

endmodule

// File: tb/tb_dioptase_mem.sv
module tb_dioptase_mem;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [17:0] raddr0;
    logic [31:0] rdata0;
    logic        ren;
    logic [17:0] raddr1;
    logic [31:0] rdata1;
    logic [3:0]  wen;
    logic [17:0] waddr;
    logic [31:0] wdata;
    logic        ps2_ren;
    logic [15:0] ps2_data_in;
    logic [9:0]  pixel_x_in;
    logic [9:0]  pixel_y_in;
    logic [11:0] pixel;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_wen;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ren;
    logic        sd_spi_cs;
    logic        sd_spi_clk;
    logic        sd_spi_mosi;
    logic        sd_spi_miso;
    logic [15:0] interrupts;

    int passed;
    int total;

    dioptase_mem #(
        .RAM_WORDS (16384),
        .INIT_FILE (""),
        .FB_BASE   (18'h30000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .raddr0       (raddr0),
        .rdata0       (rdata0),
        .ren          (ren),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .ps2_ren      (ps2_ren),
        .ps2_data_in  (ps2_data_in),
        .pixel_x_in   (pixel_x_in),
        .pixel_y_in   (pixel_y_in),
        .pixel        (pixel),
        .uart_tx_data (uart_tx_data),
        .uart_tx_wen  (uart_tx_wen),
        .uart_rx_data (uart_rx_data),
        .uart_rx_ren  (uart_rx_ren),
        .sd_spi_cs    (sd_spi_cs),
        .sd_spi_clk   (sd_spi_clk),
        .sd_spi_mosi  (sd_spi_mosi),
        .sd_spi_miso  (sd_spi_miso),
        .interrupts   (interrupts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0 got=%h exp=%h", rdata0, 32'h0); else passed++;
        total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'h0); else passed++;
        total++; if (pixel !== 12'h0) $display("FAIL reset_pixel got=%h exp=%h", pixel, 12'h0); else passed++;
        total++; if ({ps2_ren, uart_rx_ren, uart_tx_wen} !== 3'b000)
            $display("FAIL reset_pulses got=%b exp=%b", {ps2_ren, uart_rx_ren, uart_tx_wen}, 3'b000); else passed++;
        total++; if (uart_tx_data !== 8'h0) $display("FAIL reset_tx_data got=%h exp=%h", uart_tx_data, 8'h0); else passed++;
        total++; if ({sd_spi_mosi, sd_spi_clk, sd_spi_cs} !== 3'b101)
            $display("FAIL reset_spi got=%b exp=%b", {sd_spi_mosi, sd_spi_clk, sd_spi_cs}, 3'b101); else passed++;
        total++; if (interrupts !== 16'h0) $display("FAIL reset_irq got=%h exp=%h", interrupts, 16'h0); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_byte_write();
        waddr = 18'h10; wdata = 32'hDEADBEEF; wen = 4'hF;
        step();
        wen = 4'b0010; wdata = 32'h0000AA00;
        step();
        wen = 4'h0; raddr0 = 18'h10; raddr1 = 18'h10; ren = 1'b1;
        step();
        ren = 1'b0;
        total++; if (rdata0 !== 32'hDEADAAEF) $display("FAIL bytewr_rdata0 got=%h exp=%h", rdata0, 32'hDEADAAEF); else passed++;
        total++; if (rdata1 !== 32'hDEADAAEF) $display("FAIL bytewr_rdata1 got=%h exp=%h", rdata1, 32'hDEADAAEF); else passed++;
    endtask

    task automatic test_read_before_write();
        raddr0 = 18'h10; raddr1 = 18'h10; ren = 1'b1;
        waddr = 18'h10; wdata = 32'h1; wen = 4'hF;
        step();
        wen = 4'h0;
        total++; if (rdata0 !== 32'hDEADAAEF) $display("FAIL rbw_old_rdata0 got=%h exp=%h", rdata0, 32'hDEADAAEF); else passed++;
        total++; if (rdata1 !== 32'hDEADAAEF) $display("FAIL rbw_old_rdata1 got=%h exp=%h", rdata1, 32'hDEADAAEF); else passed++;
        step();
        ren = 1'b0;
        total++; if (rdata0 !== 32'h1) $display("FAIL rbw_new_rdata0 got=%h exp=%h", rdata0, 32'h1); else passed++;
        total++; if (rdata1 !== 32'h1) $display("FAIL rbw_new_rdata1 got=%h exp=%h", rdata1, 32'h1); else passed++;
    endtask

    task automatic test_clk_en_freeze();
        clk_en = 1'b0;
        raddr0 = 18'h11;
        waddr = 18'h3FFF1; wdata = 32'h41; wen = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (uart_tx_wen !== 1'b0) $display("FAIL freeze_tx_wen got=%b exp=%b", uart_tx_wen, 1'b0); else passed++;
            total++; if (rdata0 !== 32'h1) $display("FAIL freeze_rdata0 got=%h exp=%h", rdata0, 32'h1); else passed++;
        end
        total++; if (uart_tx_data !== 8'h00) $display("FAIL freeze_tx_data got=%h exp=%h", uart_tx_data, 8'h00); else passed++;
        clk_en = 1'b1;
        step();
        wen = 4'h0;
        total++; if (uart_tx_wen !== 1'b1) $display("FAIL tx_pulse got=%b exp=%b", uart_tx_wen, 1'b1); else passed++;
        total++; if (uart_tx_data !== 8'h41) $display("FAIL tx_data got=%h exp=%h", uart_tx_data, 8'h41); else passed++;
        step();
        total++; if (uart_tx_wen !== 1'b0) $display("FAIL tx_pulse_end got=%b exp=%b", uart_tx_wen, 1'b0); else passed++;
    endtask

    task automatic test_ps2_uart_rx();
        ps2_data_in = 16'h001C; raddr1 = 18'h3FFF0; ren = 1'b1;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'h1C) $display("FAIL ps2_rdata got=%h exp=%h", rdata1, 32'h1C); else passed++;
        total++; if (ps2_ren !== 1'b1) $display("FAIL ps2_pulse got=%b exp=%b", ps2_ren, 1'b1); else passed++;
        step();
        total++; if (ps2_ren !== 1'b0) $display("FAIL ps2_pulse_end got=%b exp=%b", ps2_ren, 1'b0); else passed++;
        total++; if (rdata1 !== 32'h1C) $display("FAIL ps2_hold got=%h exp=%h", rdata1, 32'h1C); else passed++;
        uart_rx_data = 8'h5A; raddr1 = 18'h3FFF2; ren = 1'b1;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'h5A) $display("FAIL rx_rdata got=%h exp=%h", rdata1, 32'h5A); else passed++;
        total++; if ({uart_rx_ren, ps2_ren} !== 2'b10) $display("FAIL rx_pulse got=%b exp=%b", {uart_rx_ren, ps2_ren}, 2'b10); else passed++;
        step();
        total++; if (uart_rx_ren !== 1'b0) $display("FAIL rx_pulse_end got=%b exp=%b", uart_rx_ren, 1'b0); else passed++;
    endtask

    task automatic test_spi();
        sd_spi_miso = 1'b1;
        waddr = 18'h3FFF3; wdata = 32'h6; wen = 4'b1000;
        step();
        wen = 4'h0;
        total++; if ({sd_spi_mosi, sd_spi_clk, sd_spi_cs} !== 3'b110)
            $display("FAIL spi_pins got=%b exp=%b", {sd_spi_mosi, sd_spi_clk, sd_spi_cs}, 3'b110); else passed++;
        raddr1 = 18'h3FFF3; ren = 1'b1;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'hE) $display("FAIL spi_read got=%h exp=%h", rdata1, 32'hE); else passed++;
    endtask

    task automatic test_timer();
        logic       exp_irq;
        logic       seen;
        waddr = 18'h3FFF4; wdata = 32'd5; wen = 4'b0001;
        step();
        wen = 4'h0;
        raddr1 = 18'h3FFF5; ren = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            ren = 1'b0;
            if (k == 1) begin
                total++; if (rdata1 !== 32'd5) $display("FAIL timer_count_read got=%h exp=%h", rdata1, 32'd5); else passed++;
            end
            exp_irq = (k % 5 == 0);
            total++; if (interrupts !== {15'h0, exp_irq})
                $display("FAIL timer_irq_k%0d got=%h exp=%h", k, interrupts, {15'h0, exp_irq}); else passed++;
        end
        wdata = 32'd0; wen = 4'b0001;
        step();
        wen = 4'h0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (interrupts[0]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL timer_disabled_irq got=%b exp=%b", seen, 1'b0); else passed++;
        raddr1 = 18'h3FFF5; ren = 1'b1;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'd0) $display("FAIL timer_disabled_count got=%h exp=%h", rdata1, 32'd0); else passed++;
    endtask

    task automatic test_framebuffer();
        waddr = 18'h300A2; wdata = 32'hFFFF_FF0F; wen = 4'b0001;
        pixel_x_in = 10'd8; pixel_y_in = 10'd4;
        step();
        wen = 4'h0;
        step();
        total++; if (pixel !== 12'hF0F) $display("FAIL fb_pixel got=%h exp=%h", pixel, 12'hF0F); else passed++;
        raddr1 = 18'h300A2; ren = 1'b1; raddr0 = 18'h300A2;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'h0000_0F0F) $display("FAIL fb_cpu_read got=%h exp=%h", rdata1, 32'h0000_0F0F); else passed++;
        total++; if (rdata0 !== 32'h0) $display("FAIL fb_fetch_zero got=%h exp=%h", rdata0, 32'h0); else passed++;
        pixel_x_in = 10'd640;
        step();
        total++; if (pixel !== 12'h000) $display("FAIL fb_x_edge got=%h exp=%h", pixel, 12'h000); else passed++;
        pixel_x_in = 10'd11; pixel_y_in = 10'd7;
        step();
        total++; if (pixel !== 12'hF0F) $display("FAIL fb_same_cell got=%h exp=%h", pixel, 12'hF0F); else passed++;
        pixel_x_in = 10'd8; pixel_y_in = 10'd480;
        step();
        total++; if (pixel !== 12'h000) $display("FAIL fb_y_edge got=%h exp=%h", pixel, 12'h000); else passed++;
        pixel_y_in = 10'd4;
        clk_en = 1'b0;
        step();
        clk_en = 1'b1;
        total++; if (pixel !== 12'hF0F) $display("FAIL fb_ignores_clk_en got=%h exp=%h", pixel, 12'hF0F); else passed++;
    endtask

    task automatic test_unmapped();
        waddr = 18'h20000; wdata = 32'hFFFF_FFFF; wen = 4'hF;
        step();
        wen = 4'h0;
        raddr1 = 18'h20000; ren = 1'b1;
        step();
        total++; if (rdata1 !== 32'h0) $display("FAIL unmapped_read got=%h exp=%h", rdata1, 32'h0); else passed++;
        raddr1 = 18'h3FFF6;
        step();
        ren = 1'b0;
        total++; if (rdata1 !== 32'h0) $display("FAIL unmapped_mmio got=%h exp=%h", rdata1, 32'h0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        raddr0 = 18'h10; raddr1 = 18'h10; ren = 1'b1;
        waddr = 18'h3FFF4; wdata = 32'd3; wen = 4'b0001;
        step();
        ren = 1'b0; wen = 4'h0;
        step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (rdata0 !== 32'h0) $display("FAIL midrst_rdata0 got=%h exp=%h", rdata0, 32'h0); else passed++;
        total++; if (rdata1 !== 32'h0) $display("FAIL midrst_rdata1 got=%h exp=%h", rdata1, 32'h0); else passed++;
        total++; if (pixel !== 12'h0) $display("FAIL midrst_pixel got=%h exp=%h", pixel, 12'h0); else passed++;
        total++; if (uart_tx_data !== 8'h0) $display("FAIL midrst_tx_data got=%h exp=%h", uart_tx_data, 8'h0); else passed++;
        total++; if ({sd_spi_mosi, sd_spi_clk, sd_spi_cs} !== 3'b101)
            $display("FAIL midrst_spi got=%b exp=%b", {sd_spi_mosi, sd_spi_clk, sd_spi_cs}, 3'b101); else passed++;
        total++; if (interrupts !== 16'h0) $display("FAIL midrst_irq got=%h exp=%h", interrupts, 16'h0); else passed++;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (interrupts[0]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL midrst_timer_off got=%b exp=%b", seen, 1'b0); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n = 1'b1; clk_en = 1'b1;
        raddr0 = '0; raddr1 = '0; ren = 1'b0;
        wen = '0; waddr = '0; wdata = '0;
        ps2_data_in = '0; pixel_x_in = '0; pixel_y_in = '0;
        uart_rx_data = '0; sd_spi_miso = 1'b0;

        test_reset();
        test_byte_write();
        test_read_before_write();
        test_clk_en_freeze();
        test_ps2_uart_rx();
        test_spi();
        test_timer();
        test_framebuffer();
        test_unmapped();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
